fetch_redirect_arbiter: RTL
===========================

# fetch_redirect_arbiter

Collects front-end redirect requests from three branch-resolution units and the trap unit, selects the single architecturally-oldest one, and drives the misprediction/correct-PC/bubble controls of the superscalar PC controller. It owns the post-redirect flush window, holding fetch bubbled for a configurable number of cycles while the backend squashes younger work. It sits between execute/commit and the fetch-stage PC controller.

## Interface
- ADDR_WIDTH, 32, PC/target width
- ROB_IDX_W, 5, ROB index width; age arithmetic is modulo 2^ROB_IDX_W
- FLUSH_CYCLES, 2, bubble cycles after each issued redirect (legal 1..15)
- RESET_PC, 32'h80000000, reset value of correct_pc_o
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- br_valid_i  in  3  per-unit redirect pulse (bit n = branch unit n)
- br_rob_idx_i  in  3*ROB_IDX_W  packed ROB index per unit, unit 0 in LSBs
- br_target_i  in  3*ADDR_WIDTH  packed corrected target per unit
- rob_head_i  in  ROB_IDX_W  current ROB head (oldest in-flight entry)
- trap_valid_i  in  1  trap/exception redirect pulse
- trap_target_i  in  ADDR_WIDTH  trap vector
- misprediction_o  out  1  one-cycle redirect strobe to PC controller
- correct_pc_o  out  ADDR_WIDTH  redirect target; valid while misprediction_o=1
- buble_o  out  1  fetch hold during flush window
- flush_o  out  1  backend squash strobe, coincident with misprediction_o
- flush_all_o  out  1  squash everything (trap); coincident with flush_o
- flush_rob_idx_o  out  ROB_IDX_W  squash entries younger than this index
- busy_o  out  1  state != IDLE

## Operation
- Age of index x = (x - rob_head_i) mod 2^ROB_IDX_W; smaller age = older.
- Candidate selection (combinational, per cycle): trap_valid_i beats all branches; else the valid branch with the smallest age; equal age → lowest unit number.
- FSM states: IDLE, ISSUE, FLUSH.
- IDLE: any candidate → latch target/idx/trap flag, go ISSUE.
- ISSUE (exactly one cycle unless re-issued): misprediction_o=flush_o=1; flush_all_o=latched trap flag; buble_o=1. Next: FLUSH with counter=FLUSH_CYCLES-1 (FLUSH_CYCLES=1 → IDLE directly).
- FLUSH: buble_o=1, others 0; counter decrements; at 0 → IDLE.
- Pre-emption in ISSUE or FLUSH: new trap always re-latches and returns to ISSUE; new branch re-latches only if no trap is active and its age is strictly less than the active index's age; otherwise dropped (already squashed).
- Reset mid-operation: returns to IDLE next edge, all pending state discarded.

## Timing
- All outputs are registered; request seen at edge t → misprediction_o high in cycle t+1.
- Redirect-to-unbubble: 1 + FLUSH_CYCLES cycles per issued redirect; pre-emption restarts the count.
- Requests in IDLE are never lost; dropped requests only occur per pre-emption rule.
- Reset values: misprediction_o=0, flush_o=0, flush_all_o=0, buble_o=0, busy_o=0, correct_pc_o=RESET_PC, flush_rob_idx_o=0, counter=0, state IDLE, perf counters 0.
- rob_head_i sampled on the same edge as the requests it is compared against.

## Configuration
- REDIRECT_PERF_CNT_EN defined: adds outputs perf_redirects_o[31:0] (increments on every ISSUE cycle) and perf_bubble_cycles_o[31:0] (increments every cycle buble_o=1); both wrap at 2^32, reset to 0.
- Undefined: both outputs present and tied to 0; no counter flops.

## Test plan
- Reset: hold reset 2 cycles with br_valid_i=3'b111 → all outputs at reset values, correct_pc_o=32'h80000000, state IDLE afterward.
- Single branch: rob_head=0, unit1 idx=5 target=32'h80000100 at t → t+1 misprediction_o=flush_o=1, correct_pc_o=32'h80000100, flush_rob_idx_o=5; buble_o=1 for t+1..t+3; busy_o low at t+4.
- Oldest select with wrap: rob_head=30, unit0 idx=2 (age 4), unit2 idx=31 (age 1) → redirect to unit2 target, flush_rob_idx_o=31.
- Trap priority: trap_valid_i with branch same cycle → correct_pc_o=trap_target_i, flush_all_o=1; older branch arriving during FLUSH dropped.
- Pre-emption: active idx=10 (head 0), branch idx=4 in FLUSH → second ISSUE, flush_rob_idx_o=4, bubble restarts; later idx=12 → ignored, no strobe.
- REDIRECT_PERF_CNT_EN: three non-overlapping redirects, FLUSH_CYCLES=2 → perf_redirects_o=3, perf_bubble_cycles_o=9; undefined → both 0.

Source files
------------

// File: rtl/fetch_redirect_arbiter.sv
// Selects the oldest front-end redirect (trap first, then smallest ROB age) and runs the post-redirect flush window.
// Optional REDIRECT_PERF_CNT_EN adds redirect / bubble-cycle performance counters.
module fetch_redirect_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ROB_IDX_W = 5,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h80000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              br_valid_i,
    input  logic [3*ROB_IDX_W-1:0]  br_rob_idx_i,
    input  logic [3*ADDR_WIDTH-1:0] br_target_i,
    input  logic [ROB_IDX_W-1:0]    rob_head_i,
    input  logic                    trap_valid_i,
    input  logic [ADDR_WIDTH-1:0]   trap_target_i,
    output logic                    misprediction_o,
    output logic [ADDR_WIDTH-1:0]   correct_pc_o,
    output logic                    buble_o,
    output logic                    flush_o,
    output logic                    flush_all_o,
    output logic [ROB_IDX_W-1:0]    flush_rob_idx_o,
    output logic                    busy_o,
    output logic [31:0]             perf_redirects_o,
    output logic [31:0]             perf_bubble_cycles_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t                  state;
    logic [3:0]              cnt;
    logic [ROB_IDX_W-1:0]    act_idx;
    logic                    act_trap;

    logic                    cand_valid;
    logic                    cand_trap;
    logic [ROB_IDX_W-1:0]    cand_idx;
    logic [ROB_IDX_W-1:0]    cand_age;
    logic [ADDR_WIDTH-1:0]   cand_target;
    logic [ROB_IDX_W-1:0]    act_age;
    logic [ROB_IDX_W-1:0]    unit_age;
    logic                    take;

    // Traps squash everything, so their flush index is simply the current head.
    always_comb begin
        cand_valid  = 1'b0;
        cand_trap   = 1'b0;
        cand_idx    = '0;
        cand_age    = '1;
        cand_target = '0;
        unit_age    = '0;
        if (trap_valid_i) begin
            cand_valid  = 1'b1;
            cand_trap   = 1'b1;
            cand_idx    = rob_head_i;
            cand_age    = '0;
            cand_target = trap_target_i;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                unit_age = br_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W] - rob_head_i;
                if (br_valid_i[i] && (!cand_valid || unit_age < cand_age)) begin
                    cand_valid  = 1'b1;
                    cand_idx    = br_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W];
                    cand_age    = unit_age;
                    cand_target = br_target_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end
        act_age = act_idx - rob_head_i;
        take = cand_valid &&
               (state == IDLE || cand_trap || (!act_trap && cand_age < act_age));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            act_idx         <= '0;
            act_trap        <= 1'b0;
            misprediction_o <= 1'b0;
            flush_o         <= 1'b0;
            flush_all_o     <= 1'b0;
            buble_o         <= 1'b0;
            busy_o          <= 1'b0;
            correct_pc_o    <= RESET_PC;
            flush_rob_idx_o <= '0;
        end else if (take) begin
            state           <= ISSUE;
            cnt             <= '0;
            act_idx         <= cand_idx;
            act_trap        <= cand_trap;
            misprediction_o <= 1'b1;
            flush_o         <= 1'b1;
            flush_all_o     <= cand_trap;
            buble_o         <= 1'b1;
            busy_o          <= 1'b1;
            correct_pc_o    <= cand_target;
            flush_rob_idx_o <= cand_idx;
        end else begin
            misprediction_o <= 1'b0;
            flush_o         <= 1'b0;
            flush_all_o     <= 1'b0;
            case (state)
                ISSUE: begin
                    if (FLUSH_CYCLES <= 1) begin
                        state   <= IDLE;
                        buble_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end else begin
                        state <= FLUSH;
                        cnt   <= FLUSH_INIT;
                    end
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        state   <= IDLE;
                        buble_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    buble_o <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

`ifdef REDIRECT_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_redirects_o     <= '0;
            perf_bubble_cycles_o <= '0;
        end else begin
            perf_redirects_o     <= perf_redirects_o + {31'd0, misprediction_o};
            perf_bubble_cycles_o <= perf_bubble_cycles_o + {31'd0, buble_o};
        end
    end
`else
    assign perf_redirects_o     = '0;
    assign perf_bubble_cycles_o = '0;
`endif

endmodule
